// File: rtl/id_forward_scoreboard.sv
// ID-stage forwarding/hazard unit: shift scoreboard of in-flight register writers feeding
// per-operand bypass selects and a stall request. Optional stall counter: `ID_FWD_PERF_EN.
module id_forward_scoreboard #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        advance,
    input  logic                        flush,
    input  logic                        id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr,
    input  logic                        id_reg_write,
    input  logic [ADDR_W-1:0]           id_dst_addr,
    input  logic [SEL_W-1:0]            id_rdy_stage,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic                        stall_id
`ifdef ID_FWD_PERF_EN
    ,
    output logic [31:0]                 stall_count
`endif
);

    // Index 1 is the youngest entry (EX); index DEPTH is the oldest still able to forward.
    logic              valid_reg [1:DEPTH];
    logic [ADDR_W-1:0] dst_reg   [1:DEPTH];
    logic [SEL_W-1:0]  rdy_reg   [1:DEPTH];

    logic [SEL_W-1:0]   rdy_clamped;
    logic               capture;
    logic [NUM_SRC-1:0] hazard_vec;

    always_comb begin
        rdy_clamped = id_rdy_stage;
        if (id_rdy_stage == '0) begin
            rdy_clamped = SEL_W'(1);
        end else if (id_rdy_stage > SEL_W'(DEPTH)) begin
            rdy_clamped = SEL_W'(DEPTH);
        end
    end

    // A stalled or flushed instruction must not be recorded; a bubble enters instead.
    assign capture = id_valid & id_reg_write & (id_dst_addr != '0) & ~stall_id & ~flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                valid_reg[k] <= 1'b0;
                dst_reg[k]   <= '0;
                rdy_reg[k]   <= '0;
            end
        end else if (advance) begin
            valid_reg[1] <= capture;
            dst_reg[1]   <= capture ? id_dst_addr : '0;
            rdy_reg[1]   <= capture ? rdy_clamped : '0;
            for (int k = 2; k <= DEPTH; k++) begin
                valid_reg[k] <= valid_reg[k-1];
                dst_reg[k]   <= dst_reg[k-1];
                rdy_reg[k]   <= rdy_reg[k-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [ADDR_W-1:0] src_addr;
            logic [SEL_W-1:0]  sel_next;
            logic              hazard_next;

            assign src_addr = id_src_addr[gi*ADDR_W +: ADDR_W];

            // Scan oldest to youngest so the youngest match overwrites any older one.
            always_comb begin
                sel_next    = '0;
                hazard_next = 1'b0;
                for (int k = DEPTH; k >= 1; k--) begin
                    if (valid_reg[k] && (dst_reg[k] == src_addr) && (src_addr != '0)) begin
                        if (SEL_W'(k) >= rdy_reg[k]) begin
                            sel_next    = SEL_W'(k);
                            hazard_next = 1'b0;
                        end else begin
                            sel_next    = '0;
                            hazard_next = 1'b1;
                        end
                    end
                end
            end

            assign fwd_sel[gi*SEL_W +: SEL_W] = reset ? sel_next : '0;
            assign hazard_vec[gi]             = hazard_next;
        end
    endgenerate

    assign stall_id = reset & id_valid & ~flush & (|hazard_vec);

`ifdef ID_FWD_PERF_EN
    logic [31:0] stall_count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count_reg <= '0;
        end else if (advance && stall_id && (stall_count_reg != 32'hFFFF_FFFF)) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_id_forward_scoreboard.sv
// Directed bench for id_forward_scoreboard (DEPTH=3, NUM_SRC=2): cycle-by-cycle vector table
// plus a reset-during-stall sequence.
module tb_id_forward_scoreboard;

    localparam int ADDR_W  = 5;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;
    localparam int SEL_W   = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      advance;
    logic                      flush;
    logic                      id_valid;
    logic [NUM_SRC*ADDR_W-1:0] id_src_addr;
    logic                      id_reg_write;
    logic [ADDR_W-1:0]         id_dst_addr;
    logic [SEL_W-1:0]          id_rdy_stage;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic                      stall_id;
`ifdef ID_FWD_PERF_EN
    logic [31:0]               stall_count;
`endif

    id_forward_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_SRC (NUM_SRC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .advance      (advance),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_src_addr  (id_src_addr),
        .id_reg_write (id_reg_write),
        .id_dst_addr  (id_dst_addr),
        .id_rdy_stage (id_rdy_stage),
        .fwd_sel      (fwd_sel),
        .stall_id     (stall_id)
`ifdef ID_FWD_PERF_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       adv;
        logic       fl;
        logic       v;
        logic       rw;
        logic [4:0] dst;
        logic [1:0] rdy;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] e0;
        logic [1:0] e1;
        logic       es;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    function automatic void add(input logic adv, input logic fl, input logic v, input logic rw,
                                input int dst, input int rdy, input int s0, input int s1,
                                input int e0, input int e1, input logic es);
        vec_t t;
        t.adv = adv; t.fl = fl; t.v = v; t.rw = rw;
        t.dst = 5'(dst); t.rdy = 2'(rdy); t.s0 = 5'(s0); t.s1 = 5'(s1);
        t.e0 = 2'(e0); t.e1 = 2'(e1); t.es = es;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic adv, input logic fl, input logic v, input logic rw,
                         input logic [4:0] dst, input logic [1:0] rdy,
                         input logic [4:0] s0, input logic [4:0] s1);
        advance      = adv;
        flush        = fl;
        id_valid     = v;
        id_reg_write = rw;
        id_dst_addr  = dst;
        id_rdy_stage = rdy;
        id_src_addr  = {s1, s0};
    endtask

    initial begin
        // adv fl v rw dst rdy s0 s1 -> fwd0 fwd1 stall
        add(1,0,1,1, 8,2, 0, 0, 0,0,0);   // ALU dependency
        add(1,0,1,0, 0,0, 8, 0, 0,0,1);
        add(1,0,1,0, 0,0, 8, 0, 2,0,0);
        add(1,0,1,0, 0,0, 8, 8, 3,3,0);
        add(1,0,1,1, 9,3, 0, 0, 0,0,0);   // load-use
        add(1,0,1,0, 0,0, 0, 9, 0,0,1);
        add(1,0,1,0, 0,0, 0, 9, 0,0,1);
        add(1,0,1,0, 0,0, 0, 9, 0,3,0);
        add(1,0,1,1,10,1, 0, 0, 0,0,0);   // dst=10 into entries 2 and 3
        add(1,0,1,1,10,1,10, 0, 1,0,0);
        add(1,0,0,0, 0,0, 0, 0, 0,0,0);
        add(1,0,1,0, 0,0,10,10, 2,2,0);
        add(1,0,0,0, 0,0, 0, 0, 0,0,0);
        add(1,0,1,1, 0,1, 0, 0, 0,0,0);   // dst=0 never recorded
        add(1,0,1,1, 5,0, 0, 0, 0,0,0);   // rdy=0 clamps to 1
        add(1,0,1,0, 0,0, 5, 0, 1,0,0);
        add(1,0,1,1,12,3, 0, 0, 0,0,0);   // flush beats stall
        add(1,1,1,1,13,2,12, 0, 0,0,0);
        add(1,0,1,0, 0,0,13,12, 0,0,1);
        add(1,0,1,1,14,2, 0,12, 0,3,0);
        add(1,0,1,1,15,2,14, 0, 0,0,1);   // stalled writer not recorded
        add(1,0,1,1,15,2,14,15, 2,0,0);
        add(1,0,1,0, 0,0,15,14, 0,3,1);
        add(1,0,0,0, 0,0,15,14, 2,0,0);   // id_valid=0 never stalls
        add(1,0,1,1, 7,1, 0, 0, 0,0,0);   // youngest match wins
        add(1,0,1,1, 7,3, 7, 0, 1,0,0);
        add(1,0,1,0, 0,0, 7, 7, 0,0,1);
        add(1,0,1,0, 0,0, 7, 7, 0,0,1);
        add(1,0,1,0, 0,0, 7, 7, 3,3,0);
        add(1,0,1,1, 9,3, 0, 0, 0,0,0);   // freeze during stall
        add(0,0,1,0, 0,0, 9, 0, 0,0,1);
        add(0,0,1,0, 0,0, 9, 0, 0,0,1);
        add(0,0,1,0, 0,0, 9, 0, 0,0,1);
        add(1,0,1,0, 0,0, 9, 0, 0,0,1);
        add(1,0,1,0, 0,0, 9, 0, 0,0,1);
        add(1,0,1,0, 0,0, 9, 0, 3,0,0);
        add(1,0,1,1,11,2, 0, 0, 0,0,0);   // advance=0 beats flush
        add(0,1,1,1, 6,2,11, 0, 0,0,0);
        add(1,0,1,0, 0,0,11, 0, 0,0,1);
        add(1,0,1,0, 0,0,11, 0, 2,0,0);

        reset = 1'b0;
        drive(1, 0, 1, 1, 5'd8, 2'd2, 5'd8, 5'd8);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_stall", 32'(stall_id), 32'd0);
        chk("reset_fwd", 32'(fwd_sel), 32'd0);
        reset = 1'b1;
        drive(1, 0, 0, 0, 5'd0, 2'd0, 5'd8, 5'd0);
        #1;
        chk("post_reset_fwd", 32'(fwd_sel), 32'd0);
`ifdef ID_FWD_PERF_EN
        chk("post_reset_count", stall_count, 32'd0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].adv, vecs[i].fl, vecs[i].v, vecs[i].rw,
                  vecs[i].dst, vecs[i].rdy, vecs[i].s0, vecs[i].s1);
            #1;
            chk($sformatf("v%0d_fwd0", i), 32'(fwd_sel[1:0]), 32'(vecs[i].e0));
            chk($sformatf("v%0d_fwd1", i), 32'(fwd_sel[3:2]), 32'(vecs[i].e1));
            chk($sformatf("v%0d_stall", i), 32'(stall_id), 32'(vecs[i].es));
`ifdef ID_FWD_PERF_EN
            chk($sformatf("v%0d_count", i), stall_count, 32'(exp_cnt));
`endif
            $display("vec %0d: src={%0d,%0d} fwd={%0d,%0d} stall=%0d", i,
                     vecs[i].s0, vecs[i].s1, fwd_sel[1:0], fwd_sel[3:2], stall_id);
            if (vecs[i].adv && vecs[i].es) exp_cnt++;
        end

        // Reset asserted while a load-use stall is pending
        @(negedge clk);
        drive(1, 0, 1, 1, 5'd9, 2'd3, 5'd0, 5'd0);
        @(negedge clk);
        drive(1, 0, 1, 0, 5'd0, 2'd0, 5'd9, 5'd0);
        #1;
        chk("midstall_pre_stall", 32'(stall_id), 32'd1);
        exp_cnt++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midstall_rst_stall", 32'(stall_id), 32'd0);
        chk("midstall_rst_fwd", 32'(fwd_sel), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midstall_post_stall", 32'(stall_id), 32'd0);
        chk("midstall_post_fwd", 32'(fwd_sel), 32'd0);
`ifdef ID_FWD_PERF_EN
        chk("midstall_post_count", stall_count, 32'd0);
`endif
        $display("reset mid-stall: fwd=%0d stall=%0d (prior stalls %0d)", fwd_sel, stall_id, exp_cnt);
        @(negedge clk);
        drive(1, 0, 1, 0, 5'd0, 2'd0, 5'd9, 5'd11);
        #1;
        chk("after_reset_stall", 32'(stall_id), 32'd0);
        chk("after_reset_fwd", 32'(fwd_sel), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
